// File: rtl/lectura_contadores.sv
// Readout sequencer for the four per-FIFO word counters: sweeps idx 0..3 over
// the req/valid handshake and holds the returned counts until the next sweep.
module lectura_contadores #(
    parameter int unsigned DATA_W  = 5,
    parameter int unsigned TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              idle_in,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              req,
    output logic [1:0]        idx,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [3:0]        error,
    output logic [DATA_W-1:0] cnt0,
    output logic [DATA_W-1:0] cnt1,
    output logic [DATA_W-1:0] cnt2,
    output logic [DATA_W-1:0] cnt3
);

    localparam int unsigned TMR_W   = 4;
    localparam int unsigned NUM_CNT = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        k;
    logic [TMR_W-1:0]  timer;
    logic [DATA_W-1:0] cnt_q [NUM_CNT];

    logic timer_exp;
    assign timer_exp = (TMR_W'(timer + TMR_W'(1)) == TMR_W'(TIMEOUT));

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

    // Sequencer; req/done/abort are single-cycle pulses defaulting low each edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            k     <= 2'd0;
            timer <= '0;
            req   <= 1'b0;
            idx   <= 2'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
            error <= 4'd0;
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            req   <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && idle_in) begin
                        k     <= 2'd0;
                        error <= 4'd0;
                        req   <= 1'b1;
                        idx   <= 2'd0;
                        busy  <= 1'b1;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    timer <= '0;
                    if (!idle_in) begin
                        abort <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Losing idle wins over a same-edge capture.
                    if (!idle_in) begin
                        abort <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (valid_in || timer_exp) begin
                        cnt_q[k] <= valid_in ? data_in : '0;
                        if (!valid_in) begin
                            error[k] <= 1'b1;
                        end
                        if (k == 2'd3) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            k     <= 2'(k + 2'd1);
                            idx   <= 2'(k + 2'd1);
                            req   <= 1'b1;
                            state <= S_REQ;
                        end
                    end else begin
                        timer <= TMR_W'(timer + TMR_W'(1));
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lectura_contadores.sv
// Directed bench for lectura_contadores with a registered counter-block model
// that answers one cycle after req.
module tb_lectura_contadores;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       idle_in;
    logic       valid_in = 1'b0;
    logic [4:0] data_in = 5'd0;
    logic       req;
    logic [1:0] idx;
    logic       busy;
    logic       done;
    logic       abort;
    logic [3:0] error;
    logic [4:0] cnt0, cnt1, cnt2, cnt3;

    lectura_contadores #(.DATA_W(5), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .idle_in(idle_in),
        .valid_in(valid_in), .data_in(data_in), .req(req), .idx(idx),
        .busy(busy), .done(done), .abort(abort), .error(error),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    always #5 clk = ~clk;

    // Counter block model: registers the count one edge after seeing req.
    logic [4:0] vals [4];
    logic [3:0] resp_en = 4'hF;
    logic       pend = 1'b0;
    logic [1:0] pend_idx = 2'd0;
    always @(negedge clk) begin
        valid_in = pend;
        data_in  = vals[pend_idx];
        pend     = req && resp_en[idx];
        pend_idx = idx;
    end

    int         checks = 0;
    int         failures = 0;
    int         cyc;
    int         req_n, done_n, abort_n, done_cyc;
    int         req_cyc [4];
    logic [1:0] req_idx [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; req_n = 0; done_n = 0; abort_n = 0; done_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            req_cyc[i] = -1;
            req_idx[i] = 2'd0;
        end
    endtask

    // Advance to the next falling edge and log output activity for that cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (req) begin
            if (req_n < 4) begin
                req_cyc[req_n] = cyc;
                req_idx[req_n] = idx;
            end
            req_n++;
        end
        if (done) begin
            done_n++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (abort) abort_n++;
    endtask

    task automatic sweep(input bit hold_start, input int drop_at);
        clear_mon();
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!hold_start) start = 1'b0;
            if (cyc == drop_at) idle_in = 1'b0;
            if (done || abort) break;
        end
        start = 1'b0;
        check("sweep_ends", 32'(done | abort), 32'd1);
    endtask

    task automatic check_counts(input string tag, input logic [4:0] c0, input logic [4:0] c1,
                                input logic [4:0] c2, input logic [4:0] c3);
        check({tag, "_cnt0"}, 32'(cnt0), 32'(c0));
        check({tag, "_cnt1"}, 32'(cnt1), 32'(c1));
        check({tag, "_cnt2"}, 32'(cnt2), 32'(c2));
        check({tag, "_cnt3"}, 32'(cnt3), 32'(c3));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; idle_in = 1'b1;
        vals[0] = 5'd7; vals[1] = 5'd12; vals[2] = 5'd0; vals[3] = 5'd31;
        clear_mon();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state after three idle cycles
        repeat (3) tick();
        check("rst_req", 32'(req), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_abort", 32'({done, abort}), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check_counts("rst", 5'd0, 5'd0, 5'd0, 5'd0);

        // start ignored while system not idle
        clear_mon();
        idle_in = 1'b0; start = 1'b1;
        repeat (5) tick();
        check("noidle_req_n", 32'(req_n), 32'd0);
        check("noidle_busy", 32'(busy), 32'd0);
        start = 1'b0; idle_in = 1'b1;
        tick();

        // Nominal sweep
        sweep(1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("nom_req_cyc%0d", i), 32'(req_cyc[i]), 32'(2 * i + 1));
            check($sformatf("nom_req_idx%0d", i), 32'(req_idx[i]), 32'(i));
        end
        check("nom_req_n", 32'(req_n), 32'd4);
        check("nom_done_cyc", 32'(done_cyc), 32'd9);
        check("nom_busy_in_done", 32'(busy), 32'd0);
        check("nom_error", 32'(error), 32'd0);
        check_counts("nom", 5'd7, 5'd12, 5'd0, 5'd31);
        tick();
        check("nom_done_pulse", 32'(done), 32'd0);

        // Timeout on index 2
        vals[0] = 5'd3; vals[1] = 5'd9; vals[2] = 5'd25; vals[3] = 5'd17;
        resp_en = 4'b1011;
        sweep(1'b0, -1);
        check("to_done_cyc", 32'(done_cyc), 32'd12);
        check("to_req3_cyc", 32'(req_cyc[3]), 32'd10);
        check("to_error", 32'(error), 32'b0100);
        check_counts("to", 5'd3, 5'd9, 5'd0, 5'd17);
        resp_en = 4'hF;
        tick();

        // Abort during S_WAIT of index 1
        vals[0] = 5'd20; vals[1] = 5'd21; vals[2] = 5'd22; vals[3] = 5'd23;
        sweep(1'b0, 4);
        check("ab_cyc", 32'(cyc), 32'd5);
        check("ab_abort_n", 32'(abort_n), 32'd1);
        check("ab_done_n", 32'(done_n), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_error", 32'(error), 32'd0);
        check_counts("ab", 5'd20, 5'd9, 5'd0, 5'd17);
        idle_in = 1'b1;
        tick();
        check("ab_abort_pulse", 32'(abort), 32'd0);
        tick();
        sweep(1'b0, -1);
        check("ab2_done_cyc", 32'(done_cyc), 32'd9);
        check_counts("ab2", 5'd20, 5'd21, 5'd22, 5'd23);
        tick();

        // Reset during S_REQ of index 2
        clear_mon();
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
        end
        check("mid_req_before_rst", 32'({req, idx}), 32'({1'b1, 2'd2}));
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(req), 32'd0);
        check("mid_rst_busy_idx", 32'({busy, idx}), 32'd0);
        check_counts("mid_rst", 5'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick();
        check("mid_rst_no_abort", 32'(abort_n), 32'd0);

        // start held through the whole sweep: one sweep, four requests
        vals[0] = 5'd1; vals[1] = 5'd2; vals[2] = 5'd4; vals[3] = 5'd8;
        sweep(1'b1, -1);
        repeat (2) tick();
        check("hold_req_n", 32'(req_n), 32'd4);
        check("hold_done_cyc", 32'(done_cyc), 32'd9);
        check("hold_busy_after", 32'(busy), 32'd0);
        check_counts("hold", 5'd1, 5'd2, 5'd4, 5'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
